// File: rtl/cdc_handshake_tx_if.sv
// Bus bundle for the source side of the toggle req/ack CDC handshake:
// upstream valid/ready word interface plus the crossing req/ack/data signals.
interface cdc_handshake_tx_if #(
    parameter int DATA_W = 8
);
    logic              i_valid;
    logic              i_ready;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] data_o;
    logic              req_o;
    logic              ack_i;
    logic              busy_o;
    logic              err_o;

    modport master (
        output i_valid, i_data, ack_i,
        input  i_ready, data_o, req_o, busy_o, err_o
    );

    modport slave (
        input  i_valid, i_data, ack_i,
        output i_ready, data_o, req_o, busy_o, err_o
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Transmitter end of a toggle-based req/ack CDC handshake: latches a word,
// toggles req_o, and waits for the synchronized ack toggle to match it.
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               aclk,
    input  logic               arstn,
    cdc_handshake_tx_if.slave  bus
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     req_q, req_d;
    logic                     err_q, err_d;
    logic [SYNC_STAGES-1:0]   ack_sync_q;
    logic                     ack_sync;

    // ack_i is asynchronous; only the last stage of this chain is ever used
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_i};
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    data_d  = bus.i_data;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
                // An ack toggle with nothing outstanding means the peer is out of step
                if (ack_sync != req_q) begin
                    err_d = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req_q) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.i_ready = (state_q == IDLE);
    assign bus.busy_o  = (state_q == WAIT_ACK);
    assign bus.data_o  = data_q;
    assign bus.req_o   = req_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed self-checking bench for cdc_handshake_tx: reset, single transfer,
// hold stability, back-to-back with an echoing destination, spurious ack, async reset.
module tb_cdc_handshake_tx;

    logic aclk;
    logic arstn;
    int   total;
    int   passed;
    logic exp_req;

    cdc_handshake_tx_if #(.DATA_W(8)) bus ();

    cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .aclk  (aclk),
        .arstn (arstn),
        .bus   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        arstn       = 1'b0;
        bus.i_valid = 1'b0;
        bus.ack_i   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_data = 8'($urandom);
            #10;
        end
        exp_req = 1'b0;
        total++;
        if (bus.i_ready !== 1'b1 || bus.req_o !== 1'b0 || bus.data_o !== 8'h00 ||
            bus.busy_o !== 1'b0 || bus.err_o !== 1'b0)
            $display("FAIL reset_hold: got rdy=%b req=%b data=%h busy=%b err=%b, want 1 0 00 0 0",
                     bus.i_ready, bus.req_o, bus.data_o, bus.busy_o, bus.err_o);
        else passed++;
        step();
        arstn = 1'b1;
        step();
        total++;
        if (bus.i_ready !== 1'b1 || bus.req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.err_o !== 1'b0)
            $display("FAIL reset_release: got rdy=%b req=%b busy=%b err=%b, want 1 0 0 0",
                     bus.i_ready, bus.req_o, bus.busy_o, bus.err_o);
        else passed++;
    endtask

    task automatic test_single_transfer();
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hA5;
        step();
        bus.i_valid = 1'b0;
        exp_req = ~exp_req;
        total++;
        if (bus.data_o !== 8'hA5 || bus.req_o !== 1'b1 || bus.i_ready !== 1'b0 || bus.busy_o !== 1'b1)
            $display("FAIL single_accept: got data=%h req=%b rdy=%b busy=%b, want a5 1 0 1",
                     bus.data_o, bus.req_o, bus.i_ready, bus.busy_o);
        else passed++;
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.data_o !== 8'hA5 || bus.req_o !== 1'b1 || bus.i_ready !== 1'b0) bad++;
        end
        bus.i_valid = 1'b0;
        total++;
        if (bad != 0)
            $display("FAIL hold_stable: got %0d cycles with data/req/ready disturbed, want 0 (data now %h)",
                     bad, bus.data_o);
        else passed++;
    endtask

    task automatic test_ack_latency();
        bus.ack_i = 1'b1;
        step();
        total++;
        if (bus.i_ready !== 1'b0)
            $display("FAIL ack_edge1: got rdy=%b, want 0", bus.i_ready);
        else passed++;
        step();
        total++;
        if (bus.i_ready !== 1'b0 || bus.busy_o !== 1'b1)
            $display("FAIL ack_edge2: got rdy=%b busy=%b, want 0 1", bus.i_ready, bus.busy_o);
        else passed++;
        step();
        total++;
        if (bus.i_ready !== 1'b1 || bus.busy_o !== 1'b0 || bus.err_o !== 1'b0)
            $display("FAIL ack_edge3: got rdy=%b busy=%b err=%b, want 1 0 0",
                     bus.i_ready, bus.busy_o, bus.err_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        logic [7:0] last_word;
        logic       last_req;
        logic       accept_now;
        int         idx, toggles, countdown, cyc, bad_hold;
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03;
        idx = 0; toggles = 0; countdown = 0; cyc = 0; bad_hold = 0;
        last_word = bus.data_o;
        last_req  = bus.req_o;
        while (cyc < 200 && !(idx == 3 && bus.i_ready === 1'b1)) begin
            bus.i_valid = (idx < 3);
            bus.i_data  = (idx < 3) ? seq[idx] : 8'h00;
            accept_now  = bus.i_valid && (bus.i_ready === 1'b1);
            step();
            cyc++;
            if (accept_now) begin
                exp_req = ~exp_req;
                total++;
                if (bus.data_o !== seq[idx] || bus.req_o !== exp_req)
                    $display("FAIL b2b_word%0d: got data=%h req=%b, want %h %b",
                             idx, bus.data_o, bus.req_o, seq[idx], exp_req);
                else passed++;
                if (bus.req_o !== last_req) toggles++;
                idx++;
                countdown = 5;
            end else if (bus.data_o !== last_word || bus.req_o !== last_req) begin
                bad_hold++;
            end
            last_word = bus.data_o;
            last_req  = bus.req_o;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) bus.ack_i = bus.req_o;
            end
        end
        bus.i_valid = 1'b0;
        total++;
        if (cyc >= 200)
            $display("FAIL b2b_timeout: got %0d cycles with %0d words, want 3 words within 200", cyc, idx);
        else passed++;
        total++;
        if (toggles != 3 || bad_hold != 0)
            $display("FAIL b2b_toggles: got toggles=%0d stray_changes=%0d, want 3 0", toggles, bad_hold);
        else passed++;
        total++;
        if (bus.data_o !== 8'h03 || bus.req_o !== 1'b0 || bus.err_o !== 1'b0)
            $display("FAIL b2b_final: got data=%h req=%b err=%b, want 03 0 0",
                     bus.data_o, bus.req_o, bus.err_o);
        else passed++;
    endtask

    task automatic test_spurious_ack();
        bus.ack_i = 1'b1;
        step();
        step();
        step();
        total++;
        if (bus.err_o !== 1'b1 || bus.i_ready !== 1'b1)
            $display("FAIL spurious_set: got err=%b rdy=%b, want 1 1", bus.err_o, bus.i_ready);
        else passed++;
        bus.ack_i = 1'b0;
        repeat (5) step();
        total++;
        if (bus.err_o !== 1'b1 || bus.i_ready !== 1'b1 || bus.req_o !== 1'b0 || bus.data_o !== 8'h03)
            $display("FAIL spurious_sticky: got err=%b rdy=%b req=%b data=%h, want 1 1 0 03",
                     bus.err_o, bus.i_ready, bus.req_o, bus.data_o);
        else passed++;
    endtask

    task automatic test_reset_mid_transfer();
        arstn     = 1'b0;
        bus.ack_i = 1'b0;
        step();
        arstn = 1'b1;
        step();
        total++;
        if (bus.err_o !== 1'b0)
            $display("FAIL rst_clears_err: got err=%b, want 0", bus.err_o);
        else passed++;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h5A;
        step();
        bus.i_valid = 1'b0;
        total++;
        if (bus.busy_o !== 1'b1 || bus.data_o !== 8'h5A || bus.req_o !== 1'b1)
            $display("FAIL rst_mid_setup: got busy=%b data=%h req=%b, want 1 5a 1",
                     bus.busy_o, bus.data_o, bus.req_o);
        else passed++;
        step();
        #2;
        arstn = 1'b0;
        #1;
        total++;
        if (bus.req_o !== 1'b0 || bus.data_o !== 8'h00 || bus.busy_o !== 1'b0 || bus.i_ready !== 1'b1)
            $display("FAIL rst_mid_async: got req=%b data=%h busy=%b rdy=%b, want 0 00 0 1",
                     bus.req_o, bus.data_o, bus.busy_o, bus.i_ready);
        else passed++;
        step();
        arstn = 1'b1;
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        exp_req     = 1'b0;
        arstn       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.ack_i   = 1'b0;
        test_reset();
        test_single_transfer();
        test_hold();
        test_ack_latency();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
